// File: rtl/chol_div_iter.sv
// Signed fixed-point divider (dividend << FRAC) / divisor, radix-2 restoring, saturating; latency WIDTH+FRAC enabled edges.
// Result held in DONE until out_ready; no accept until drained, so one op per WIDTH+FRAC+2 cycles.
module chol_div_iter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_dz
);

    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] MAXP     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [NW-1:0]    MAXP_EXT = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NW-1:0]    MAXN_EXT = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [NW-1:0]    num;
    logic [WIDTH:0]   rem;
    logic [NW-1:0]    q;
    logic [WIDTH-1:0] dabs;
    logic             sign;
    logic             dz;
    logic [TAG_W-1:0] tag_r;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH:0]   rem_nx;
    logic [NW-1:0]    q_nx;
    logic [WIDTH-1:0] q_lo;
    logic [WIDTH-1:0] res_q;
    logic             res_ovf;
    logic             res_dz;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Magnitudes as unsigned WIDTH-bit values; the most negative input maps to 2^(WIDTH-1) naturally.
    assign a_abs = dividend[WIDTH-1] ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    assign b_abs = divisor[WIDTH-1]  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;

    always_comb begin
        rem_sh = {rem[WIDTH-1:0], num[NW-1]};
        ge     = (rem_sh >= {1'b0, dabs});
        rem_nx = ge ? (rem_sh - {1'b0, dabs}) : rem_sh;
        q_nx   = {q[NW-2:0], ge};
        q_lo   = q_nx[WIDTH-1:0];
    end

    // Final saturation works on the quotient as it will stand after the last iteration.
    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        res_dz  = 1'b0;
        if (dz) begin
            res_dz = 1'b1;
            res_q  = sign ? MINN : MAXP;
        end else if (!sign && (q_nx > MAXP_EXT)) begin
            res_q   = MAXP;
            res_ovf = 1'b1;
        end else if (sign && (q_nx > MAXN_EXT)) begin
            res_q   = MINN;
            res_ovf = 1'b1;
        end else begin
            res_q = sign ? (-q_lo) : q_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            num      <= '0;
            rem      <= '0;
            q        <= '0;
            dabs     <= '0;
            sign     <= 1'b0;
            dz       <= 1'b0;
            tag_r    <= '0;
            quotient <= '0;
            out_tag  <= '0;
            out_ovf  <= 1'b0;
            out_dz   <= 1'b0;
        end else if (clken) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dz    <= (divisor == '0);
                        dabs  <= b_abs;
                        num   <= {a_abs, {FRAC{1'b0}}};
                        rem   <= '0;
                        q     <= '0;
                        cnt   <= CW'(NW - 1);
                        tag_r <= in_tag;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    num <= {num[NW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient <= res_q;
                        out_ovf  <= res_ovf;
                        out_dz   <= res_dz;
                        out_tag  <= tag_r;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chol_div_iter.sv
// Directed bench for chol_div_iter: hand-computed quotients, flags, tags, latency, clken and async reset.
module tb_chol_div_iter;

    logic        clk;
    logic        rst_n;
    logic        clken;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [3:0]  out_tag;
    logic        out_ovf;
    logic        out_dz;

    int errors = 0;
    int checks = 0;

    chol_div_iter #(.WIDTH(32), .FRAC(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clken     (clken),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_dz    (out_dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the result drained.
    // mode: 0 plain, 1 random clken during CALC, 2 stray in_valid during CALC, 3 hold out_ready low 10 cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                         input logic [31:0] eq, input logic eovf, input logic edz, input int mode);
        int n;
        int guard;
        check("in_ready_idle", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_tag   = t;
        in_valid = 1'b1;
        clken    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_0001;
        in_tag   = ~t;
        n = 0;
        guard = 0;
        while (!out_valid && guard < 500) begin
            if (mode == 1) clken = 1'($urandom_range(0, 1));
            if (mode == 2 && guard == 10) begin
                check("in_ready_calc", in_ready, 0);
                in_valid = 1'b1;
            end
            if (mode == 2 && guard == 11) in_valid = 1'b0;
            @(posedge clk);
            if (clken) n++;
            guard++;
            @(negedge clk);
        end
        clken = 1'b1;
        check("latency", n, 48);
        check("quotient", quotient, eq);
        check("out_ovf", out_ovf, eovf);
        check("out_dz", out_dz, edz);
        check("out_tag", out_tag, t);
        if (mode == 3) begin
            repeat (10) @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_quotient", quotient, eq);
            check("hold_tag", out_tag, t);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clken     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_tag    = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_flags", {out_ovf, out_dz}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0006_0000, 32'h0002_0000, 4'h1, 32'h0003_0000, 1'b0, 1'b0, 0);
        do_op(32'hFFFF_0000, 32'h0004_0000, 4'h2, 32'hFFFF_C000, 1'b0, 1'b0, 3);
        do_op(32'h0001_0000, 32'h0003_0000, 4'h3, 32'h0000_5555, 1'b0, 1'b0, 0);
        do_op(32'hFFFF_0000, 32'h0003_0000, 4'h9, 32'hFFFF_AAAB, 1'b0, 1'b0, 0);
        do_op(32'h7FFF_0000, 32'h0000_0001, 4'h4, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        do_op(32'h8000_0000, 32'h0001_0000, 4'h5, 32'h8000_0000, 1'b0, 1'b0, 2);
        do_op(32'h8000_0000, 32'h0000_8000, 4'h6, 32'h8000_0000, 1'b1, 1'b0, 0);
        do_op(32'h0001_0000, 32'h0000_0000, 4'h7, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
        do_op(32'hFFFF_0000, 32'h0000_0000, 4'h8, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op(32'hFFFF_0000, 32'h0003_0000, 4'hB, 32'hFFFF_AAAB, 1'b0, 1'b0, 1);

        // Start an op, then pull reset mid-iteration and look between clock edges.
        dividend = 32'h0006_0000;
        divisor  = 32'h0002_0000;
        in_tag   = 4'hC;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (27) @(negedge clk);
        check("pre_rst_busy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_quotient", quotient, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_flags", {out_ovf, out_dz}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h0001_0000, 32'h0003_0000, 4'hA, 32'h0000_5555, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
